// File: rtl/oursring_req_arb_pkg.sv
// oursring_req_arb_pkg: request-channel payload types and arbiter defaults
package oursring_req_arb_pkg;
  localparam int ORING_REQ_ARB_N_REQ_DEFAULT = 4;
  localparam int ORING_REQ_ARB_WQ_DEPTH_DEFAULT = 4;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
  } oursring_req_if_aw_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } oursring_req_if_w_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
  } oursring_req_if_ar_t;
  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;
endpackage

// File: rtl/oursring_req_arb_if.sv
// oursring_req_arb_if: N-wide AW/W/AR valid-ready bundle (N=1 for the ring side)
interface oursring_req_arb_if #(parameter int N = 1);
  import oursring_req_arb_pkg::*;
  oursring_req_if_aw_t [N-1:0] aw;
  logic [N-1:0] awvalid;
  logic [N-1:0] awready;
  oursring_req_if_w_t [N-1:0] w;
  logic [N-1:0] wvalid;
  logic [N-1:0] wready;
  oursring_req_if_ar_t [N-1:0] ar;
  logic [N-1:0] arvalid;
  logic [N-1:0] arready;
  modport master(output aw, awvalid, w, wvalid, ar, arvalid, input awready, wready, arready);
  modport slave(input aw, awvalid, w, wvalid, ar, arvalid, output awready, wready, arready);
endinterface

// File: rtl/oursring_req_arb_rr.sv
// oursring_rr_arb: round-robin pick, grant lock until handshake, pointer advance
module oursring_rr_arb
  import oursring_req_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          hold_off,
  input  logic          done,
  output logic          locked,
  output logic [IW-1:0] gnt
);
  arb_state_e state, state_d;
  logic [IW-1:0] ptr, pick, gnt_d;
  logic [2*N-1:0] rot;
  logic [IW:0] sum;
  logic start;
  assign locked = state == ARB_LOCK;
  assign start = !locked && |req && !hold_off;
  // rot[k] is the requester k places after ptr; the lowest set k wins
  always_comb begin
    rot = {req, req} >> ptr;
    sum = '0;
    pick = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (rot[k]) pick = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    end
  end
  always_comb begin
    state_d = locked ? (done ? ARB_IDLE : ARB_LOCK) : (start ? ARB_LOCK : ARB_IDLE);
    gnt_d = start ? pick : gnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt <= '0;
      ptr <= '0;
    end else begin
      state <= state_d;
      gnt <= gnt_d;
      if (locked && done) ptr <= (gnt == IW'(N - 1)) ? '0 : gnt + IW'(1);
    end
  end
endmodule

// File: rtl/oursring_req_arb.sv
// oursring_req_arb: N-to-1 AW/W/AR arbiter with W steered in AW-grant order
module oursring_req_arb
  import oursring_req_arb_pkg::*;
#(
  parameter int N_REQ = ORING_REQ_ARB_N_REQ_DEFAULT,
  parameter int WQ_DEPTH = ORING_REQ_ARB_WQ_DEPTH_DEFAULT,
  localparam int IW = $clog2(N_REQ),
  localparam int PW = $clog2(WQ_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  oursring_req_arb_if.slave  i_req_if,
  oursring_req_arb_if.master o_req_if,
  output logic [IW-1:0]      o_aw_src,
  output logic [IW-1:0]      o_ar_src
);
  logic ar_locked, aw_locked, ar_done, aw_done, w_done, wq_full, wq_empty;
  logic [IW-1:0] wq [WQ_DEPTH];
  logic [PW-1:0] wq_rd, wq_wr;
  logic [PW:0] wq_cnt;
  logic [IW-1:0] w_head;
  oursring_rr_arb #(.N(N_REQ)) u_ar_arb (
    .clk, .rst, .req(i_req_if.arvalid), .hold_off(1'b0), .done(ar_done),
    .locked(ar_locked), .gnt(o_ar_src)
  );
  oursring_rr_arb #(.N(N_REQ)) u_aw_arb (
    .clk, .rst, .req(i_req_if.awvalid), .hold_off(wq_full), .done(aw_done),
    .locked(aw_locked), .gnt(o_aw_src)
  );
  assign wq_full = wq_cnt == (PW+1)'(WQ_DEPTH);
  assign wq_empty = wq_cnt == '0;
  assign w_head = wq[wq_rd];
  assign ar_done = o_req_if.arvalid[0] & o_req_if.arready[0];
  assign aw_done = o_req_if.awvalid[0] & o_req_if.awready[0];
  assign w_done = o_req_if.wvalid[0] & o_req_if.wready[0];
  always_comb begin
    o_req_if.ar[0] = i_req_if.ar[o_ar_src];
    o_req_if.arvalid[0] = ar_locked & i_req_if.arvalid[o_ar_src];
    i_req_if.arready = '0;
    i_req_if.arready[o_ar_src] = ar_locked & o_req_if.arready[0];
  end
  // a full queue also gates a locked AW so no handshake can go unrecorded
  always_comb begin
    o_req_if.aw[0] = i_req_if.aw[o_aw_src];
    o_req_if.awvalid[0] = aw_locked & ~wq_full & i_req_if.awvalid[o_aw_src];
    i_req_if.awready = '0;
    i_req_if.awready[o_aw_src] = aw_locked & ~wq_full & o_req_if.awready[0];
  end
  always_comb begin
    o_req_if.w[0] = i_req_if.w[w_head];
    o_req_if.wvalid[0] = ~wq_empty & i_req_if.wvalid[w_head];
    i_req_if.wready = '0;
    i_req_if.wready[w_head] = ~wq_empty & o_req_if.wready[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wq <= '{default: '0};
      wq_rd <= '0;
      wq_wr <= '0;
      wq_cnt <= '0;
    end else begin
      if (aw_done) begin
        wq[wq_wr] <= o_aw_src;
        wq_wr <= wq_wr + PW'(1);
      end
      if (w_done) wq_rd <= wq_rd + PW'(1);
      wq_cnt <= wq_cnt + (PW+1)'(aw_done) - (PW+1)'(w_done);
    end
  end
  assert property (@(posedge clk) disable iff (rst)
    o_req_if.arvalid[0] && !o_req_if.arready[0] |=> o_req_if.arvalid[0] && $stable(o_req_if.ar[0]));
  assert property (@(posedge clk) disable iff (rst)
    o_req_if.awvalid[0] && !o_req_if.awready[0] |=> o_req_if.awvalid[0] && $stable(o_req_if.aw[0]));
  assert property (@(posedge clk) disable iff (rst)
    o_req_if.wvalid[0] && !o_req_if.wready[0] |=> o_req_if.wvalid[0] && $stable(o_req_if.w[0]));
  assert property (@(posedge clk) disable iff (rst) !(aw_done && wq_full) && !(w_done && wq_empty));
  assert property (@(posedge clk)
    $onehot0(i_req_if.arready) && $onehot0(i_req_if.awready) && $onehot0(i_req_if.wready));
endmodule
